// File: rtl/grf_pkg.sv
// -----------------------------------------------------------------------------
// grf_pkg - shared definitions for the multi-port general register file.
//
// Contents:
//   ZERO_REG      index of the hardwired-zero register
//   sat_cnt_step  pending-counter update: cnt + inc - dec, floored at 0
//
// The write-trace line printed by grf_mp has the layout
//   "%d@%h: $%d <= %h"  (time, writing PC, register index, data).
// -----------------------------------------------------------------------------
package grf_pkg;

    // Register 0 always reads as zero and never holds a pending write.
    localparam int unsigned ZERO_REG = 0;

    // Saturating add/sub with a floor at zero. Retiring a register that was
    // never issued is legal, so the subtraction must not wrap. The ceiling is
    // enforced upstream: an increment is only offered when the counter is
    // not already full.
    function automatic int unsigned sat_cnt_step(input int unsigned cnt,
                                                 input int unsigned inc,
                                                 input int unsigned dec);
        if (cnt + inc > dec) begin
            return cnt + inc - dec;
        end
        return 0;
    endfunction

endpackage

// File: rtl/grf_mp_if.sv
// -----------------------------------------------------------------------------
// grf_mp_if - bus bundle between the pipeline and the register file.
//
// Signals (flattened per port, port k occupies slice k):
//   rd_addr   read addresses               master -> slave
//   rd_data   read data (combinational)    slave  -> master
//   rd_busy   read register pending        slave  -> master
//   wr_en     write/retire strobe per port master -> slave
//   wr_addr   write addresses              master -> slave
//   wr_data   write data                   master -> slave
//   wr_pc     PC of the writer, trace only master -> slave
//   iss_en    issue strobe                 master -> slave
//   iss_addr  destination of the issue     master -> slave
//   iss_stall issue rejected this cycle    slave  -> master
//   busy_vec  registered busy bit per reg  slave  -> master
//
// Handshake: an issue is taken at the rising edge when iss_en is high and
// iss_stall is low in that cycle; when iss_stall is high the master holds
// iss_en/iss_addr and retries. Writes have no back-pressure: every enabled
// write port is taken at the edge it is presented.
// -----------------------------------------------------------------------------
interface grf_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_WR*32-1:0]     wr_pc;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     iss_stall;
    logic [2**ADDR_W-1:0]     busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr,
        input  rd_data, rd_busy, iss_stall, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr,
        output rd_data, rd_busy, iss_stall, busy_vec
    );
endinterface

// File: rtl/grf_sb_cnt.sv
// -----------------------------------------------------------------------------
// grf_sb_cnt - pending-write counter for one register.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous, active-low reset
//   inc_i   in   accepted issue to this register (already gated by stall)
//   dec_i   in   number of write ports retiring to this register (0..2)
//   cnt_o   out  current count
//   busy_o  out  registered, count != 0
//   full_o  out  count at its maximum; further issues must stall
// -----------------------------------------------------------------------------
module grf_sb_cnt
    import grf_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic [1:0]       dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             busy_o,
    output logic             full_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_comb begin
        cnt_d  = CNT_W'(sat_cnt_step(32'(cnt_q), 32'(inc_i), 32'(dec_i)));
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = busy_q;
    assign full_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/grf_mp.sv
// -----------------------------------------------------------------------------
// grf_mp - parametrised multi-port general register file with a pending-write
// scoreboard for RAW hazard detection.
//
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   reset  in   synchronous, active-low reset
//   bus    slave side of grf_mp_if (reads, writes/retires, issue, busy)
//
// Behaviour summary:
//   - register 0 reads as zero, ignores writes, never becomes busy;
//   - write ports with a higher index win on an address collision;
//   - BYPASS=1 forwards same-cycle write data to reads and subtracts
//     same-cycle retires from rd_busy;
//   - each register r != 0 owns a grf_sb_cnt counting issued-but-unretired
//     writes; an issue to a full counter raises iss_stall and is dropped;
//   - TRACE=1 logs every accepted write in simulation.
// -----------------------------------------------------------------------------
module grf_mp
    import grf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int CNT_W  = 2,
    parameter bit BYPASS = 1'b1,
    parameter bit TRACE  = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    grf_mp_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;

    // Unpacked views of the flattened port buses.
    logic [ADDR_W-1:0] rd_addr_a [NUM_RD];
    logic [ADDR_W-1:0] wr_addr_a [NUM_WR];
    logic [DATA_W-1:0] wr_data_a [NUM_WR];
    logic [31:0]       wr_pc_a   [NUM_WR];

    // Register array.
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Scoreboard wiring, one entry per register.
    logic [1:0]        dec_a  [DEPTH];
    logic [CNT_W-1:0]  cnt_a  [DEPTH];
    logic [DEPTH-1:0]  inc_v;
    logic [DEPTH-1:0]  busy_v;
    logic [DEPTH-1:0]  full_v;

    logic                     iss_stall;
    logic [NUM_RD*DATA_W-1:0] rd_data_flat;
    logic [NUM_RD-1:0]        rd_busy_flat;
    logic [DATA_W-1:0]        rd_val;

    // ------------------------------------------------------------------
    // Bus unpacking
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr_a[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
        end
        for (int j = 0; j < NUM_WR; j++) begin
            wr_addr_a[j] = bus.wr_addr[j*ADDR_W +: ADDR_W];
            wr_data_a[j] = bus.wr_data[j*DATA_W +: DATA_W];
            wr_pc_a[j]   = bus.wr_pc[j*32 +: 32];
        end
    end

    // ------------------------------------------------------------------
    // Write path: ports applied in ascending order so the highest index
    // wins a collision. Register 0 is never written.
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && (32'(wr_addr_a[j]) != ZERO_REG)) begin
                regs_d[wr_addr_a[j]] = wr_data_a[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: retire count per register and issue acceptance.
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            dec_a[r] = 2'd0;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j]) begin
                dec_a[wr_addr_a[j]] = dec_a[wr_addr_a[j]] + 2'd1;
            end
        end
    end

    // full_v[0] is tied low, so an issue to register 0 never stalls.
    assign iss_stall = bus.iss_en && (32'(bus.iss_addr) != ZERO_REG) &&
                       full_v[bus.iss_addr];

    assign inc_v[0]  = 1'b0;
    assign cnt_a[0]  = '0;
    assign busy_v[0] = 1'b0;
    assign full_v[0] = 1'b0;

    for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
        assign inc_v[r] = bus.iss_en && (bus.iss_addr == ADDR_W'(r)) && !iss_stall;

        grf_sb_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .inc_i  (inc_v[r]),
            .dec_i  (dec_a[r]),
            .cnt_o  (cnt_a[r]),
            .busy_o (busy_v[r]),
            .full_o (full_v[r])
        );
    end

    // ------------------------------------------------------------------
    // Read path: zero register, optional bypass, then stored value.
    // rd_busy looks only at retires; a same-cycle issue is not visible.
    // ------------------------------------------------------------------
    always_comb begin
        rd_data_flat = '0;
        rd_busy_flat = '0;
        rd_val       = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_val = regs_q[rd_addr_a[i]];
            if (BYPASS) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.wr_en[j] && (wr_addr_a[j] == rd_addr_a[i])) begin
                        rd_val = wr_data_a[j];
                    end
                end
            end
            if (32'(rd_addr_a[i]) == ZERO_REG) begin
                rd_val = '0;
            end
            rd_data_flat[i*DATA_W +: DATA_W] = rd_val;

            if (BYPASS) begin
                rd_busy_flat[i] = (sat_cnt_step(32'(cnt_a[rd_addr_a[i]]), 0,
                                                32'(dec_a[rd_addr_a[i]])) != 0);
            end else begin
                rd_busy_flat[i] = (cnt_a[rd_addr_a[i]] != '0);
            end
        end
    end

    assign bus.rd_data   = rd_data_flat;
    assign bus.rd_busy   = rd_busy_flat;
    assign bus.iss_stall = iss_stall;
    assign bus.busy_vec  = busy_v;

    // ------------------------------------------------------------------
    // Write trace (simulation log). Ports print in ascending order, so an
    // overridden lower-port write still appears, before the winner.
    // ------------------------------------------------------------------
    if (TRACE) begin : g_trace
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.wr_en[j] && (32'(wr_addr_a[j]) != ZERO_REG)) begin
                        $display("%d@%h: $%d <= %h", $time, wr_pc_a[j],
                                 wr_addr_a[j], wr_data_a[j]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_grf_mp.sv
// -----------------------------------------------------------------------------
// tb_grf_mp - directed bench for grf_mp. Two instances share one stimulus:
// dut_byp (BYPASS=1) and dut_nob (BYPASS=0). Inputs change 1 time unit after
// a rising edge; combinational outputs are checked 1 unit later, registered
// results after the next edge.
// -----------------------------------------------------------------------------
module tb_grf_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    grf_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus_byp ();
    grf_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus_nob ();

    // The non-bypass instance mirrors every input of the bypass instance.
    assign bus_nob.rd_addr  = bus_byp.rd_addr;
    assign bus_nob.wr_en    = bus_byp.wr_en;
    assign bus_nob.wr_addr  = bus_byp.wr_addr;
    assign bus_nob.wr_data  = bus_byp.wr_data;
    assign bus_nob.wr_pc    = bus_byp.wr_pc;
    assign bus_nob.iss_en   = bus_byp.iss_en;
    assign bus_nob.iss_addr = bus_byp.iss_addr;

    grf_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
        .CNT_W(2), .BYPASS(1'b1), .TRACE(1'b1)
    ) dut_byp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_byp)
    );

    grf_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
        .CNT_W(2), .BYPASS(1'b0), .TRACE(1'b1)
    ) dut_nob (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nob)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rdat_byp(input int p);
        return bus_byp.rd_data[p*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] rdat_nob(input int p);
        return bus_nob.rd_data[p*DATA_W +: DATA_W];
    endfunction

    // ---------------- drivers ----------------
    task automatic set_rd(input int p, input logic [ADDR_W-1:0] a);
        bus_byp.rd_addr[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        bus_byp.wr_en[p]                    = en;
        bus_byp.wr_addr[p*ADDR_W +: ADDR_W] = a;
        bus_byp.wr_data[p*DATA_W +: DATA_W] = d;
        bus_byp.wr_pc[p*32 +: 32]           = 32'h0000_1000 + 32'(p * 4);
    endtask

    task automatic set_iss(input logic en, input logic [ADDR_W-1:0] a);
        bus_byp.iss_en   = en;
        bus_byp.iss_addr = a;
    endtask

    task automatic idle();
        set_wr(0, 1'b0, '0, '0);
        set_wr(1, 1'b0, '0, '0);
        set_iss(1'b0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus_byp.rd_addr = '0;
        idle();
        tick();
        tick();
        reset = 1'b1;

        // Reset state.
        set_rd(0, 5'd5);
        set_rd(1, 5'd6);
        set_iss(1'b1, 5'd9);
        #1;
        chk("reset_rd0", rdat_byp(0), 0);
        chk("reset_rd1", rdat_byp(1), 0);
        chk("reset_busy_vec", bus_byp.busy_vec, 0);
        chk("reset_rd_busy", bus_byp.rd_busy, 0);
        chk("reset_iss_stall", bus_byp.iss_stall, 0);
        set_iss(1'b0, '0);

        // Plain write then readback.
        set_wr(0, 1'b1, 5'd5, 32'h1234);
        tick();
        idle();
        #1;
        chk("wr5_byp", rdat_byp(0), 32'h1234);
        chk("wr5_nob", rdat_nob(0), 32'h1234);

        // Reset with a write and an issue presented: both discarded.
        reset = 1'b0;
        set_wr(0, 1'b1, 5'd6, 32'hFFFF);
        set_iss(1'b1, 5'd6);
        tick();
        reset = 1'b1;
        idle();
        #1;
        chk("rst_clear_r5", rdat_byp(0), 0);
        chk("rst_drop_r6", rdat_byp(1), 0);
        chk("rst_drop_r6_nob", rdat_nob(1), 0);
        chk("rst_busy_vec", bus_byp.busy_vec, 0);

        // Dual-write collision on $3: port 1 wins.
        set_rd(0, 5'd3);
        set_wr(0, 1'b1, 5'd3, 32'hAAAA);
        set_wr(1, 1'b1, 5'd3, 32'h5555);
        #1;
        chk("coll_bypass", rdat_byp(0), 32'h5555);
        chk("coll_nobypass", rdat_nob(0), 32'h0);
        tick();
        idle();
        #1;
        chk("coll_stored_byp", rdat_byp(0), 32'h5555);
        chk("coll_stored_nob", rdat_nob(0), 32'h5555);

        // Zero register: write and issue are ignored.
        set_rd(0, 5'd0);
        set_wr(0, 1'b1, 5'd0, 32'hDEAD);
        set_iss(1'b1, 5'd0);
        #1;
        chk("zero_stall", bus_byp.iss_stall, 0);
        chk("zero_rd_bypass", rdat_byp(0), 0);
        tick();
        idle();
        #1;
        chk("zero_rd_after", rdat_byp(0), 0);
        chk("zero_rd_after_nob", rdat_nob(0), 0);
        chk("zero_busy_vec", bus_byp.busy_vec, 0);

        // Bypass on $7: stored 1, same-cycle write of 2.
        set_wr(0, 1'b1, 5'd7, 32'h1);
        tick();
        set_wr(0, 1'b1, 5'd7, 32'h2);
        set_rd(1, 5'd7);
        #1;
        chk("byp7_byp", rdat_byp(1), 32'h2);
        chk("byp7_nob", rdat_nob(1), 32'h1);
        tick();
        idle();
        #1;
        chk("byp7_stored", rdat_nob(1), 32'h2);

        // Scoreboard on $9.
        set_iss(1'b1, 5'd9);
        tick();                                   // count 1
        chk("sb9_busy_after_1", bus_byp.busy_vec[9], 1);
        tick();                                   // count 2
        set_wr(0, 1'b1, 5'd9, 32'h99);
        tick();                                   // issue + retire: stays 2
        set_wr(0, 1'b0, '0, '0);
        #1;
        chk("sb9_net_not_full", bus_byp.iss_stall, 0);
        tick();                                   // count 3
        chk("sb9_full_stall", bus_byp.iss_stall, 1);
        tick();                                   // rejected, held at 3
        chk("sb9_held_stall", bus_byp.iss_stall, 1);
        chk("sb9_held_busy", bus_byp.busy_vec[9], 1);
        set_iss(1'b0, '0);
        set_rd(0, 5'd9);
        set_wr(0, 1'b1, 5'd9, 32'h9A);
        set_wr(1, 1'b1, 5'd9, 32'h9B);
        #1;
        chk("sb9_rdbusy_3m2_byp", bus_byp.rd_busy[0], 1);
        chk("sb9_rdbusy_3m2_nob", bus_nob.rd_busy[0], 1);
        tick();                                   // two retires: 3 -> 1
        idle();
        set_wr(0, 1'b1, 5'd9, 32'h9C);
        #1;
        chk("sb9_rdbusy_1m1_byp", bus_byp.rd_busy[0], 0);
        chk("sb9_rdbusy_1m1_nob", bus_nob.rd_busy[0], 1);
        chk("sb9_busy_at_1", bus_byp.busy_vec[9], 1);
        tick();                                   // 1 -> 0
        idle();
        #1;
        chk("sb9_busy_at_0", bus_byp.busy_vec[9], 0);
        chk("sb9_rdbusy_0", bus_nob.rd_busy[0], 0);
        set_wr(0, 1'b1, 5'd9, 32'h9D);
        tick();                                   // retire at 0: floor
        idle();
        #1;
        chk("sb9_floor_busy", bus_byp.busy_vec[9], 0);
        set_iss(1'b1, 5'd9);
        tick();                                   // 0 -> 1
        idle();
        #1;
        chk("sb9_floor_issue", bus_byp.busy_vec[9], 1);
        chk("sb9_floor_not_full", bus_byp.iss_stall, 0);
        set_wr(1, 1'b1, 5'd9, 32'h9E);
        tick();                                   // 1 -> 0
        idle();
        #1;
        chk("sb9_floor_retire", bus_byp.busy_vec[9], 0);

        // rd_busy bypass on $4 with count 1.
        set_iss(1'b1, 5'd4);
        tick();
        idle();
        set_rd(1, 5'd4);
        #1;
        chk("rb4_busy_byp", bus_byp.rd_busy[1], 1);
        chk("rb4_busy_nob", bus_nob.rd_busy[1], 1);
        set_iss(1'b1, 5'd4);
        #1;
        chk("rb4_iss_no_effect_byp", bus_byp.rd_busy[1], 1);
        chk("rb4_iss_no_effect_nob", bus_nob.rd_busy[1], 1);
        set_iss(1'b0, '0);
        set_wr(1, 1'b1, 5'd4, 32'h44);
        #1;
        chk("rb4_retire_byp", bus_byp.rd_busy[1], 0);
        chk("rb4_retire_nob", bus_nob.rd_busy[1], 1);
        tick();
        idle();
        #1;
        chk("rb4_after_byp", bus_byp.rd_busy[1], 0);
        chk("rb4_after_nob", bus_nob.rd_busy[1], 0);
        chk("rb4_data", rdat_nob(1), 32'h44);
        chk("final_busy_vec", bus_nob.busy_vec, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
